// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package inst_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_OUT  = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [63:0] FETCH_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam int unsigned INST_W           = 32;

endpackage

// File: rtl/inst_fetch_ctrl_lane_sel.sv
// Selects the 32-bit instruction lane of a read beat using pc[2].
module inst_lane_sel
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] data,
  input  logic              sel,
  output logic [INST_W-1:0] lane
);

  assign lane = sel ? data[DATA_W-1 -: INST_W] : data[INST_W-1:0];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Multicycle fetch controller: issues one aligned memory read per PC and
// hands the selected instruction to decode over valid/ready.
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_rready,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              inst_ready,
  output logic              pc_we,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_q;
  logic              drop_q;
  logic [INST_W-1:0] lane;

  inst_lane_sel #(.DATA_W(DATA_W)) u_lane_sel (
    .data (mem_rdata),
    .sel  (pc_q[2]),
    .lane (lane)
  );

  // PC advance must coincide with the accept cycle, so it is not registered.
  assign pc_we = inst_valid & inst_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc_q        <= '0;
      drop_q      <= 1'b0;
      mem_arvalid <= 1'b0;
      mem_araddr  <= '0;
      mem_rready  <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      inst_fault  <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_req && !flush) begin
            pc_q <= pc_addr;
            if (pc_addr[1:0] != 2'b00) begin
              // Misaligned PC faults without touching memory.
              state      <= ST_OUT;
              inst_valid <= 1'b1;
              inst_fault <= 1'b1;
              inst       <= '0;
              inst_pc    <= pc_addr;
            end else begin
              state       <= ST_AR;
              mem_arvalid <= 1'b1;
              mem_araddr  <= pc_addr & ADDR_W'(FETCH_ALIGN_MASK);
            end
          end
        end
        ST_AR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
            if (drop_q || flush) begin
              drop_q <= 1'b1;
              state  <= ST_DROP;
            end else begin
              state <= ST_R;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        ST_R: begin
          if (mem_rvalid) begin
            mem_rready <= 1'b0;
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              inst       <= lane;
              inst_pc    <= pc_q;
              inst_fault <= (mem_rresp != RESP_OKAY);
              inst_valid <= 1'b1;
              state      <= ST_OUT;
            end
          end else if (flush) begin
            state <= ST_DROP;
          end
        end
        ST_DROP: begin
          // Swallow the beat of the abandoned read before issuing another.
          if (mem_rvalid) begin
            mem_rready <= 1'b0;
            drop_q     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (flush) begin
            inst_valid <= 1'b0;
            state      <= ST_IDLE;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + CNT_W'(1);
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with an expected-instruction queue.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [63:0] pc_addr;
  logic        flush;
  logic        mem_arvalid;
  logic [63:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready;
  logic        pc_we;
  logic [31:0] fetch_cnt;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int          n_chk;
  int          n_fail;
  int          exp_cnt;

  inst_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .pc_addr     (pc_addr),
    .flush       (flush),
    .mem_arvalid (mem_arvalid),
    .mem_araddr  (mem_araddr),
    .mem_arready (mem_arready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rready  (mem_rready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_fault  (inst_fault),
    .inst_ready  (inst_ready),
    .pc_we       (pc_we),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] pc, input logic f);
    exp_t e;
    e.inst = i; e.pc = pc; e.fault = f;
    sb.push_back(e);
  endtask

  // Compare the presented instruction with the oldest expectation, then accept it.
  task automatic accept(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(inst_valid), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_inst"}, 64'(inst), 64'(e.inst));
      chk({tag, "_pc"}, inst_pc, e.pc);
      chk({tag, "_fault"}, 64'(inst_fault), 64'(e.fault));
    end
    chk({tag, "_pcwe_pre"}, 64'(pc_we), 64'd0);
    inst_ready = 1'b1;
    #1;
    chk({tag, "_pcwe"}, 64'(pc_we), 64'd1);
    tick();
    inst_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_pcwe_post"}, 64'(pc_we), 64'd0);
    chk({tag, "_valid_post"}, 64'(inst_valid), 64'd0);
    chk({tag, "_cnt"}, 64'(fetch_cnt), 64'(exp_cnt));
  endtask

  // Zero-wait fetch: AR at cycle 1, R at cycle 2, instruction at cycle 3.
  task automatic fetch_fast(input string tag, input logic [63:0] pc, input logic [63:0] rd,
                            input logic [1:0] resp, input logic [31:0] ei, input logic ef);
    push(ei, pc, ef);
    pc_addr = pc; fetch_req = 1'b1; mem_arready = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = rd; mem_rresp = resp;
    tick();
    fetch_req = 1'b0;
    chk({tag, "_arvalid"}, 64'(mem_arvalid), 64'd1);
    chk({tag, "_araddr"}, mem_araddr, pc & 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk({tag, "_rready"}, 64'(mem_rready), 64'd1);
    chk({tag, "_valid_c2"}, 64'(inst_valid), 64'd0);
    tick();
    mem_rvalid = 1'b0; mem_arready = 1'b0;
    chk({tag, "_rready_off"}, 64'(mem_rready), 64'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_cnt = 0;
    rst = 1'b1; fetch_req = 1'b0; pc_addr = '0; flush = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = 2'b00;
    inst_ready = 1'b0;
    #12;
    chk("rst_arvalid", 64'(mem_arvalid), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    rst = 1'b0;
    tick();

    // 1: aligned fetch, upper lane
    fetch_fast("t1", 64'h8000_0004, 64'h0050_0093_1234_5678, 2'b00, 32'h0050_0093, 1'b0);
    accept("t1");

    // 2: misaligned PC faults at cycle 1 with no memory access
    push(32'h0, 64'h8000_0002, 1'b1);
    pc_addr = 64'h8000_0002; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t2_arvalid", 64'(mem_arvalid), 64'd0);
    accept("t2");
    chk("t2_arvalid_after", 64'(mem_arvalid), 64'd0);

    // 3: address backpressure for 3 cycles
    push(32'h2222_2222, 64'h8000_0010, 1'b0);
    pc_addr = 64'h8000_0010; fetch_req = 1'b1; mem_arready = 1'b0;
    tick();
    fetch_req = 1'b0;
    pc_addr = 64'hFFFF_0000_0000_0000;
    for (int i = 0; i < 3; i++) begin
      chk("t3_arvalid_hold", 64'(mem_arvalid), 64'd1);
      chk("t3_araddr_hold", mem_araddr, 64'h8000_0010);
      tick();
    end
    mem_arready = 1'b1;
    chk("t3_araddr_hs", mem_araddr, 64'h8000_0010);
    tick();
    mem_arready = 1'b0;
    chk("t3_valid_c5", 64'(inst_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_1111_2222_2222;
    tick();
    mem_rvalid = 1'b0;
    accept("t3");

    // 4: flush while waiting for read data
    pc_addr = 64'h8000_0004; fetch_req = 1'b1; mem_arready = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    mem_arready = 1'b0;
    chk("t4_rready", 64'(mem_rready), 64'd1);
    flush = 1'b1;
    #1;
    chk("t4_pcwe_flush", 64'(pc_we), 64'd0);
    tick();
    flush = 1'b0;
    chk("t4_valid_drop", 64'(inst_valid), 64'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("t4_rready_drop", 64'(mem_rready), 64'd1);
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_valid", 64'(inst_valid), 64'd0);
      chk("t4_rready_idle", 64'(mem_rready), 64'd0);
      tick();
    end
    chk("t4_cnt", 64'(fetch_cnt), 64'(exp_cnt));
    fetch_fast("t4b", 64'h8000_0008, 64'hAAAA_AAAA_00A0_0113, 2'b00, 32'h00A0_0113, 1'b0);
    accept("t4b");

    // 5: error response with decode backpressure
    fetch_fast("t5", 64'h8000_000C, 64'hCAFE_F00D_0BAD_C0DE, 2'b10, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_valid", 64'(inst_valid), 64'd1);
      chk("t5_hold_inst", 64'(inst), 64'h0000_0000_CAFE_F00D);
      chk("t5_hold_pc", inst_pc, 64'h8000_000C);
      chk("t5_hold_pcwe", 64'(pc_we), 64'd0);
      tick();
    end
    accept("t5");

    // 6: asynchronous reset while in R
    pc_addr = 64'h8000_0020; fetch_req = 1'b1; mem_arready = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    mem_arready = 1'b0;
    chk("t6_rready", 64'(mem_rready), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rready_rst", 64'(mem_rready), 64'd0);
    chk("t6_arvalid_rst", 64'(mem_arvalid), 64'd0);
    chk("t6_araddr_rst", mem_araddr, 64'd0);
    chk("t6_valid_rst", 64'(inst_valid), 64'd0);
    chk("t6_inst_rst", 64'(inst), 64'd0);
    chk("t6_pc_rst", inst_pc, 64'd0);
    chk("t6_fault_rst", 64'(inst_fault), 64'd0);
    chk("t6_cnt_rst", 64'(fetch_cnt), 64'd0);
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    tick();
    mem_rvalid = 1'b0;
    chk("t6_stray_valid", 64'(inst_valid), 64'd0);
    chk("t6_stray_rready", 64'(mem_rready), 64'd0);
    chk("t6_cnt", 64'(fetch_cnt), 64'd0);
    fetch_fast("t6b", 64'h8000_0020, 64'h0000_0013_0000_0073, 2'b00, 32'h0000_0073, 1'b0);
    accept("t6b");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Multicycle instruction-fetch controller directly downstream of the IFU. Takes the IFU's current pc_addr and issues a read to the instruction memory over a valid/ready read channel. It extracts the 32-bit instruction from the 64-bit data beat and presents it to the IDU with a valid/ready handshake. On an accepted instruction it pulses pc_we so the IFU's PC register advances; it discards in-flight fetches on a flush.

Parameters:
ADDR_W, 64, PC and memory address width
DATA_W, 64, memory read data width (two instruction lanes)
CNT_W, 32, width of the completed-fetch counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
fetch_req  in  1  IFU has a valid pc_addr to fetch
pc_addr  in  ADDR_W  PC from IFU
flush  in  1  redirect from EXU; abort current fetch
mem_arvalid  out  1  read address valid
mem_araddr  out  ADDR_W  8-byte-aligned read address
mem_arready  in  1  memory accepts address
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data beat
mem_rresp  in  2  response, 2'b00 = OKAY
mem_rready  out  1  controller accepts data
inst_valid  out  1  instruction available to IDU
inst  out  32  fetched instruction
inst_pc  out  ADDR_W  PC of inst
inst_fault  out  1  misaligned PC or non-OKAY response
inst_ready  in  1  IDU accepts instruction
pc_we  out  1  IFU PC update enable
fetch_cnt  out  CNT_W  completed (handshaken) fetches, wraps

Behaviour:
- Reset (async, immediate): state IDLE; pc_q, inst, inst_pc, fetch_cnt = 0; all valid/ready/we/fault outputs = 0.
- FSM states are IDLE, AR, R, OUT and DROP.
- IDLE:
  - fetch_req & !flush: latch pc_q = pc_addr.
  - If pc_addr[1:0] != 0: go to OUT with inst_fault = 1 and inst = 0. No memory access is made.
  - Otherwise go to AR.
  - mem_rvalid in IDLE is ignored.
- AR:
  - mem_arvalid = 1 and mem_araddr = {pc_q[ADDR_W-1:3], 3'b000}, held stable until mem_arready.
  - arvalid is never withdrawn before the handshake.
  - A flush in AR, or in the arready cycle, sets drop_q. On arready go to DROP if drop_q or flush, else go to R.
- R:
  - mem_rready = 1.
  - On mem_rvalid & !flush: inst = pc_q[2] ? rdata[63:32] : rdata[31:0], inst_pc = pc_q, inst_fault = (rresp != 0). Go to OUT.
  - flush & rvalid in the same cycle: discard the data and go to IDLE.
  - flush without rvalid: go to DROP.
- DROP: mem_rready = 1. On mem_rvalid, discard the data, clear drop_q and go to IDLE.
- OUT:
  - inst_valid = 1. inst, inst_pc and inst_fault stay stable while inst_ready = 0.
  - pc_we = inst_valid & inst_ready & !flush, combinational in the handshake cycle.
  - On the handshake: fetch_cnt += 1 (wraps at 2^CNT_W) and go to IDLE.
  - flush has priority: go to IDLE, no pc_we, no count, inst_valid drops next cycle.
- Latency (zero-wait memory): fetch_req sampled at cycle 0 → AR at 1 → R at 2 → inst_valid at 3. Best throughput is one instruction per 4 cycles.
- Misaligned fetch: inst_valid at cycle 1.
- Only one outstanding read at a time. mem_rready is asserted only in R and DROP.

Decomposition:
- Shared package inst_fetch_pkg holds:
  - the state enum (IDLE=0, AR=1, R=2, OUT=3, DROP=4, 3-bit encoding);
  - RESP_OKAY = 2'b00;
  - FETCH_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8.
- One sub-module, inst_lane_sel: combinational selection of the 32-bit lane from the 64-bit beat by pc[2].

Test Plan:
1. Aligned fetch, high lane: pc_addr = 0x8000_0004, arready = 1, rdata = 0x00500093_12345678, rresp = 0 → araddr = 0x8000_0000; inst = 0x00500093, inst_pc = 0x8000_0004 and inst_fault = 0 at cycle 3; pc_we = 1 for exactly the inst_ready cycle; fetch_cnt = 1.
2. Misaligned PC: pc_addr = 0x8000_0002 → mem_arvalid stays 0; inst_valid at cycle 1 with inst_fault = 1 and inst = 0.
3. Address backpressure: arready = 0 for 3 cycles → arvalid = 1 and araddr stable across all 3 cycles; inst delivered 3 cycles later than in test 1.
4. Flush in flight: flush in R, rvalid 2 cycles later with rdata = 0xDEADBEEF_DEADBEEF → inst_valid never asserts, no pc_we, state IDLE; next fetch at pc 0x8000_0008 returns the correct low lane.
5. IDU backpressure and error response: rresp = 2'b10, inst_ready = 0 for 4 cycles → inst_fault = 1; inst and inst_pc stable; pc_we asserted only on the accept cycle.
6. Reset mid-operation: rst asserted while in R → all outputs 0 immediately without a clock edge; a stray rvalid after reset is ignored; fetch_cnt = 0.
